// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder step per clock, LSB first.
// A three-state FSM sequences WIDTH RUN cycles and then pulses done once.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] result_r;
  logic [CNT_W-1:0] cnt_r;
  logic             carry_r;
  logic             cout_r;
  logic             overflow_r;
  logic             busy_r;
  logic             done_r;
  logic             sum_s;
  logic             carry_s;

  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  assign sum_s   = fa_sum(a_r[0], b_r[0], carry_r);
  assign carry_s = fa_carry(a_r[0], b_r[0], carry_r);

  // Sequencing FSM, operand shifters, carry flop and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      result_r   <= '0;
      cnt_r      <= '0;
      carry_r    <= 1'b0;
      cout_r     <= 1'b0;
      overflow_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry with op.
            a_r     <= a;
            b_r     <= op ? ~b : b;
            carry_r <= op;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_r      <= {1'b0, a_r[WIDTH-1:1]};
          b_r      <= {1'b0, b_r[WIDTH-1:1]};
          result_r <= {sum_s, result_r[WIDTH-1:1]};
          carry_r  <= carry_s;
          cnt_r    <= cnt_r + 1'b1;
          if (cnt_r == LAST_BIT) begin
            // carry_r is the carry into the MSB, carry_s the carry out of it.
            cout_r     <= carry_s;
            overflow_r <= carry_r ^ carry_s;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            state_r    <= DONE;
          end else begin
            busy_r  <= 1'b1;
            state_r <= RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign result   = result_r;
  assign cout     = cout_r;
  assign overflow = overflow_r;

endmodule
